hazard_flush_ctrl: RTL and testbench

Pipeline hazard and redirect controller that generates the stall and flush controls consumed by the IF/ID and ID/EX pipeline registers and the PC source select for fetch. It compares the decode-stage instruction against the execute-stage instruction for load-use hazards and squashes wrong-path instructions on taken branches. It also sequences the multi-cycle bubbles needed for RET/RTI (stack pop) and for external interrupt entry (PC push, then vector). It sits beside the decode stage and drives `flush_E` into the ID/EX register.

---
 rtl/hazard_flush_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hazard_flush_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl
//   Stall/flush/redirect controller that sits beside the decode stage.
//   - Detects load-use hazards between the decode-stage and execute-stage
//     instructions and inserts a single bubble.
//   - Squashes wrong-path instructions when a branch resolves taken.
//   - Sequences the RET/RTI drain (stack pop) and the interrupt entry
//     (PC push, then vector).
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   RA_D, RB_D     decode-stage source register indices
//   uses_ra_D/rb_D decode-stage instruction reads RA / RB
//   rd_en_E        execute-stage instruction is a load
//   wr_en_regf_E   execute-stage instruction writes the register file
//   dest_E         execute-stage destination register
//   branch_taken_E branch resolved taken in execute
//   is_ret_E       RET/RTI in execute
//   intr           external interrupt (asynchronous level)
//   stall_F        hold the PC
//   stall_D        hold the IF/ID register
//   flush_D        clear the IF/ID register
//   flush_E        clear the ID/EX register
//   pc_sel         00 PC+1, 01 branch target, 10 popped PC, 11 vector
//   int_push       strobe: push return PC
//   intr_ack       strobe: interrupt accepted (vector cycle)
module hazard_flush_ctrl #(
    parameter int RET_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] RA_D,
    input  logic [1:0] RB_D,
    input  logic       uses_ra_D,
    input  logic       uses_rb_D,
    input  logic       rd_en_E,
    input  logic       wr_en_regf_E,
    input  logic [1:0] dest_E,
    input  logic       branch_taken_E,
    input  logic       is_ret_E,
    input  logic       intr,
    output logic       stall_F,
    output logic       stall_D,
    output logic       flush_D,
    output logic       flush_E,
    output logic [1:0] pc_sel,
    output logic       int_push,
    output logic       intr_ack
);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        RET_DRAIN  = 2'b01,
        INT_PUSH   = 2'b10,
        INT_VECTOR = 2'b11
    } state_t;

    // The first drain cycle already counts, so the counter starts one lower.
    localparam logic [2:0] RET_LOAD = 3'(RET_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] cnt;
    logic [2:0] cnt_next;

    logic       intr_sync1;
    logic       intr_sync2;
    logic       intr_prev;
    logic       intr_rise;
    logic       pending;
    logic       load_use;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Two-flop synchronizer, then an edge-detect flop on the synchronized level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            intr_sync1 <= 1'b0;
            intr_sync2 <= 1'b0;
            intr_prev  <= 1'b0;
        end else begin
            intr_sync1 <= intr;
            intr_sync2 <= intr_sync1;
            intr_prev  <= intr_sync2;
        end
    end

    assign intr_rise = intr_sync2 & ~intr_prev;

    // A new edge wins over the clear in the vector cycle, so an interrupt
    // raised exactly then is not lost; edges while pending simply merge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else begin
            pending <= (pending & (state != INT_VECTOR)) | intr_rise;
        end
    end

    assign load_use = rd_en_E & wr_en_regf_E &
                      ((uses_ra_D & (RA_D == dest_E)) |
                       (uses_rb_D & (RB_D == dest_E)));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        flush_D    = 1'b0;
        flush_E    = 1'b0;
        pc_sel     = 2'b00;
        int_push   = 1'b0;
        intr_ack   = 1'b0;

        // Outputs must be quiet while reset is held, whatever E/D present.
        if (reset) begin
            case (state)
                IDLE: begin
                    if (branch_taken_E) begin
                        flush_D = 1'b1;
                        flush_E = 1'b1;
                        pc_sel  = 2'b01;
                    end else if (is_ret_E) begin
                        flush_D    = 1'b1;
                        flush_E    = 1'b1;
                        stall_F    = 1'b1;
                        cnt_next   = RET_LOAD;
                        state_next = RET_DRAIN;
                    end else if (load_use) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        flush_E = 1'b1;
                    end else if (pending) begin
                        stall_F    = 1'b1;
                        flush_D    = 1'b1;
                        flush_E    = 1'b1;
                        int_push   = 1'b1;
                        state_next = INT_PUSH;
                    end
                end
                RET_DRAIN: begin
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                    if (cnt != 3'd0) begin
                        stall_F  = 1'b1;
                        cnt_next = cnt - 3'd1;
                    end else begin
                        pc_sel     = 2'b10;
                        state_next = IDLE;
                    end
                end
                INT_PUSH: begin
                    stall_F    = 1'b1;
                    flush_D    = 1'b1;
                    flush_E    = 1'b1;
                    state_next = INT_VECTOR;
                end
                INT_VECTOR: begin
                    pc_sel     = 2'b11;
                    intr_ack   = 1'b1;
                    flush_D    = 1'b1;
                    flush_E    = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb_hazard_flush_ctrl
//   Self-checking bench for hazard_flush_ctrl: directed scenarios with
//   expected patterns written out by hand, followed by a randomized run
//   compared against a transaction-level reference model.
//   Output vector layout: {stall_F, stall_D, flush_D, flush_E, pc_sel, int_push, intr_ack}
module tb_hazard_flush_ctrl;

    localparam int RET_CYCLES = 2;

    localparam logic [7:0] P_ZERO  = 8'b0000_0000;
    localparam logic [7:0] P_LU    = 8'b1101_0000;
    localparam logic [7:0] P_BR    = 8'b0011_0100;
    localparam logic [7:0] P_HOLD  = 8'b1011_0000;
    localparam logic [7:0] P_REDIR = 8'b0011_1000;
    localparam logic [7:0] P_IACC  = 8'b1011_0010;
    localparam logic [7:0] P_IVEC  = 8'b0011_1101;

    logic       clk;
    logic       reset;
    logic [1:0] RA_D;
    logic [1:0] RB_D;
    logic       uses_ra_D;
    logic       uses_rb_D;
    logic       rd_en_E;
    logic       wr_en_regf_E;
    logic [1:0] dest_E;
    logic       branch_taken_E;
    logic       is_ret_E;
    logic       intr;
    logic       stall_F;
    logic       stall_D;
    logic       flush_D;
    logic       flush_E;
    logic [1:0] pc_sel;
    logic       int_push;
    logic       intr_ack;
    logic [7:0] outv;

    int checks = 0;
    int errors = 0;

    hazard_flush_ctrl #(.RET_CYCLES(RET_CYCLES)) dut (
        .clk            (clk),
        .reset          (reset),
        .RA_D           (RA_D),
        .RB_D           (RB_D),
        .uses_ra_D      (uses_ra_D),
        .uses_rb_D      (uses_rb_D),
        .rd_en_E        (rd_en_E),
        .wr_en_regf_E   (wr_en_regf_E),
        .dest_E         (dest_E),
        .branch_taken_E (branch_taken_E),
        .is_ret_E       (is_ret_E),
        .intr           (intr),
        .stall_F        (stall_F),
        .stall_D        (stall_D),
        .flush_D        (flush_D),
        .flush_E        (flush_E),
        .pc_sel         (pc_sel),
        .int_push       (int_push),
        .intr_ack       (intr_ack)
    );

    assign outv = {stall_F, stall_D, flush_D, flush_E, pc_sel, int_push, intr_ack};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // plan: output patterns forced in coming cycles by an accepted multi-cycle
    // sequence (E holds NOPs, so inputs are irrelevant while it is non-empty).
    // samp: intr as seen at each clock edge since reset.
    logic [7:0] plan[$];
    logic       samp[$];
    logic       m_pend = 1'b0;

    function automatic logic model_hazard();
        logic [1:0] srcs[$];
        logic       found;
        found = 1'b0;
        if (uses_ra_D) srcs.push_back(RA_D);
        if (uses_rb_D) srcs.push_back(RB_D);
        if (rd_en_E && wr_en_regf_E)
            foreach (srcs[i]) if (srcs[i] == dest_E) found = 1'b1;
        return found;
    endfunction

    function automatic logic [7:0] model_out();
        if (!reset) return P_ZERO;
        if (plan.size() != 0) return plan[0];
        if (branch_taken_E) return P_BR;
        if (is_ret_E) return P_HOLD;
        if (model_hazard()) return P_LU;
        if (m_pend) return P_IACC;
        return P_ZERO;
    endfunction

    task automatic model_edge();
        logic vec_now;
        logic s2;
        logic s3;
        logic rise;
        int   n;
        vec_now = (plan.size() != 0) && plan[0][0];
        // A rising edge seen at edge n-2 becomes pending at edge n.
        n    = samp.size();
        s2   = (n >= 2) ? samp[n-2] : 1'b0;
        s3   = (n >= 3) ? samp[n-3] : 1'b0;
        rise = s2 && !s3;
        if (plan.size() != 0) begin
            void'(plan.pop_front());
        end else if (!branch_taken_E) begin
            if (is_ret_E) begin
                for (int k = 0; k < RET_CYCLES - 1; k++) plan.push_back(P_HOLD);
                plan.push_back(P_REDIR);
            end else if (!model_hazard() && m_pend) begin
                plan.push_back(P_HOLD);
                plan.push_back(P_IVEC);
            end
        end
        m_pend = (m_pend && !vec_now) || rise;
        samp.push_back(intr);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                plan.delete();
                samp.delete();
                m_pend = 1'b0;
            end else begin
                model_edge();
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RA_D = 2'd0; RB_D = 2'd0; uses_ra_D = 1'b0; uses_rb_D = 1'b0;
        rd_en_E = 1'b0; wr_en_regf_E = 1'b0; dest_E = 2'd0;
        branch_taken_E = 1'b0; is_ret_E = 1'b0; intr = 1'b0;
    endtask

    task automatic set_load_use_rb();
        rd_en_E = 1'b1; wr_en_regf_E = 1'b1; dest_E = 2'd2;
        RB_D = 2'd2; uses_rb_D = 1'b1; RA_D = 2'd0; uses_ra_D = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        RA_D = 2'd1; RB_D = 2'd1; uses_ra_D = 1'b1; uses_rb_D = 1'b1;
        rd_en_E = 1'b1; wr_en_regf_E = 1'b1; dest_E = 2'd1;
        branch_taken_E = 1'b1; is_ret_E = 1'b1; intr = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (outv !== P_ZERO) begin
                errors++;
                $display("FAIL reset_quiet c%0d got %b want %b", c, outv, P_ZERO);
            end
            branch_taken_E = (c == 0);
        end
        next_cycle();
        clear_inputs();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (outv !== P_ZERO) begin
                errors++;
                $display("FAIL reset_release_idle c%0d got %b want %b", c, outv, P_ZERO);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        set_load_use_rb();
        @(negedge clk);
        checks++;
        if (outv !== P_LU) begin
            errors++;
            $display("FAIL load_use_rb got %b want %b", outv, P_LU);
        end
        next_cycle();
        rd_en_E = 1'b0;
        @(negedge clk);
        checks++;
        if (outv !== P_ZERO) begin
            errors++;
            $display("FAIL load_use_bubble_clears got %b want %b", outv, P_ZERO);
        end
        next_cycle();
        clear_inputs();
        rd_en_E = 1'b1; wr_en_regf_E = 1'b1; dest_E = 2'd3; RA_D = 2'd3; uses_ra_D = 1'b1;
        @(negedge clk);
        checks++;
        if (outv !== P_LU) begin
            errors++;
            $display("FAIL load_use_ra got %b want %b", outv, P_LU);
        end
        next_cycle();
        uses_ra_D = 1'b0; uses_rb_D = 1'b1; RB_D = 2'd3;
        wr_en_regf_E = 1'b0;
        @(negedge clk);
        checks++;
        if (outv !== P_ZERO) begin
            errors++;
            $display("FAIL load_no_writeback got %b want %b", outv, P_ZERO);
        end
        next_cycle();
        wr_en_regf_E = 1'b1; RB_D = 2'd1; RA_D = 2'd3; uses_ra_D = 1'b0;
        @(negedge clk);
        checks++;
        if (outv !== P_ZERO) begin
            errors++;
            $display("FAIL load_unused_match got %b want %b", outv, P_ZERO);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_branch_over_hazard();
        clear_inputs();
        set_load_use_rb();
        branch_taken_E = 1'b1;
        @(negedge clk);
        checks++;
        if (outv !== P_BR) begin
            errors++;
            $display("FAIL branch_over_hazard got %b want %b", outv, P_BR);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (outv !== P_ZERO) begin
            errors++;
            $display("FAIL branch_stays_idle got %b want %b", outv, P_ZERO);
        end
        next_cycle();
    endtask

    task automatic test_ret();
        logic [7:0] exp_s [0:4];
        exp_s = '{P_HOLD, P_HOLD, P_REDIR, P_ZERO, P_ZERO};
        clear_inputs();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            is_ret_E       = (c == 0);
            branch_taken_E = (c == 1);
            if (c == 2) set_load_use_rb();
            @(negedge clk);
            checks++;
            if (outv !== exp_s[c]) begin
                errors++;
                $display("FAIL ret_seq c%0d got %b want %b", c, outv, exp_s[c]);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_interrupt();
        logic [7:0] exp_s [0:8];
        exp_s = '{P_ZERO, P_ZERO, P_ZERO, P_IACC, P_HOLD, P_IVEC, P_ZERO, P_ZERO, P_ZERO};
        clear_inputs();
        for (int c = 0; c < 9; c++) begin
            intr = (c == 0);
            @(negedge clk);
            checks++;
            if (outv !== exp_s[c]) begin
                errors++;
                $display("FAIL intr_seq c%0d got %b want %b", c, outv, exp_s[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_intr_second_edge();
        logic [7:0] exp_s [0:11];
        exp_s = '{P_ZERO, P_ZERO, P_ZERO, P_IACC, P_HOLD, P_IVEC,
                  P_IACC, P_HOLD, P_IVEC, P_ZERO, P_ZERO, P_ZERO};
        clear_inputs();
        for (int c = 0; c < 12; c++) begin
            intr = (c == 0) || (c == 3);
            @(negedge clk);
            checks++;
            if (outv !== exp_s[c]) begin
                errors++;
                $display("FAIL intr_second_edge c%0d got %b want %b", c, outv, exp_s[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_intr_deferred_by_ret();
        logic [7:0] exp_s [0:8];
        exp_s = '{P_ZERO, P_HOLD, P_HOLD, P_REDIR, P_IACC, P_HOLD, P_IVEC, P_ZERO, P_ZERO};
        clear_inputs();
        for (int c = 0; c < 9; c++) begin
            intr     = (c == 0);
            is_ret_E = (c == 1);
            @(negedge clk);
            checks++;
            if (outv !== exp_s[c]) begin
                errors++;
                $display("FAIL intr_deferred_by_ret c%0d got %b want %b", c, outv, exp_s[c]);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_async_reset_mid_ret();
        clear_inputs();
        intr = 1'b1;
        next_cycle();
        intr = 1'b0;
        is_ret_E = 1'b1;
        @(negedge clk);
        checks++;
        if (outv !== P_HOLD) begin
            errors++;
            $display("FAIL async_rst_ret_accept got %b want %b", outv, P_HOLD);
        end
        next_cycle();
        is_ret_E = 1'b0;
        branch_taken_E = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (outv !== P_ZERO) begin
            errors++;
            $display("FAIL async_rst_immediate got %b want %b", outv, P_ZERO);
        end
        next_cycle();
        branch_taken_E = 1'b0;
        #2;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (outv !== P_ZERO || pc_sel === 2'b10) begin
                errors++;
                $display("FAIL async_rst_after c%0d got %b want %b", c, outv, P_ZERO);
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        clear_inputs();
        for (int i = 0; i < 3000; i++) begin
            RA_D           = 2'($urandom_range(0, 3));
            RB_D           = 2'($urandom_range(0, 3));
            dest_E         = 2'($urandom_range(0, 3));
            uses_ra_D      = 1'($urandom_range(0, 1));
            uses_rb_D      = 1'($urandom_range(0, 1));
            rd_en_E        = 1'($urandom_range(0, 1));
            wr_en_regf_E   = ($urandom_range(0, 3) != 0);
            branch_taken_E = ($urandom_range(0, 9) == 0);
            is_ret_E       = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) intr = ~intr;
            if ($urandom_range(0, 399) == 0) begin
                #2;
                reset = 1'b0;
                #1;
                checks++;
                if (outv !== model_out()) begin
                    errors++;
                    $display("FAIL rand_async_reset i%0d got %b want %b", i, outv, model_out());
                end
                next_cycle();
                reset = 1'b1;
            end else begin
                @(negedge clk);
                checks++;
                if (outv !== model_out()) begin
                    errors++;
                    $display("FAIL rand_cycle i%0d got %b want %b", i, outv, model_out());
                end
                next_cycle();
            end
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch_over_hazard();
        test_ret();
        test_interrupt();
        test_intr_second_edge();
        test_intr_deferred_by_ret();
        test_async_reset_mid_ret();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
